// File: rtl/wb_regfile_unit.sv
// Write-back stage with integrated register file: selects destination/source per writeback
// type, extracts sub-word loads, stalls on late load data, and serves bypassed read ports.
module wb_regfile_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NREAD  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wb_valid,
    output logic                      wb_ready,
    input  logic [2:0]                wb_type,
    input  logic [31:0]               wb_ir,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic [DATA_W-1:0]         link_addr,
    input  logic [1:0]                ld_size,
    input  logic                      ld_signed,
    input  logic [1:0]                ld_offset,
    input  logic [DATA_W-1:0]         load_data,
    input  logic                      load_valid,
    input  logic [NREAD*ADDR_W-1:0]   rd_addr,
    output logic [NREAD*DATA_W-1:0]   rd_data,
    output logic                      fwd_en,
    output logic [ADDR_W-1:0]         fwd_addr,
    output logic [DATA_W-1:0]         fwd_data
);

    localparam int unsigned IDX_W   = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int unsigned FIELD_W = 5;
    localparam logic [2:0] WB_RR    = 3'd1;
    localparam logic [2:0] WB_RM    = 3'd2;
    localparam logic [2:0] WB_LOAD  = 3'd3;
    localparam logic [2:0] WB_LINK  = 3'd4;

    typedef enum logic {
        RUN       = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t               state;
    logic [DATA_W-1:0]    regs [NREG];
    logic [FIELD_W-1:0]   pend_dst;
    logic [1:0]           pend_size;
    logic [1:0]           pend_off;
    logic                 pend_sgn;

    logic [FIELD_W-1:0]   sel_dst;
    logic [DATA_W-1:0]    sel_data;
    logic                 do_write;
    logic                 start_wait;
    logic                 dst_ok;

    // Only the rt/rd fields of the instruction word matter here.
    logic unused_ir;
    assign unused_ir = ^{wb_ir[31:21], wb_ir[10:0]};

    // Little-endian lane select followed by sign/zero extension.
    function automatic logic [DATA_W-1:0] extract(
        input logic [DATA_W-1:0] d,
        input logic [1:0]        size,
        input logic              sgn,
        input logic [1:0]        off
    );
        logic [DATA_W-1:0] lane_b;
        logic [DATA_W-1:0] lane_h;
        lane_b = d >> {off, 3'b000};
        lane_h = d >> {off[1], 4'b0000};
        case (size)
            2'd0:    return sgn ? DATA_W'($signed(lane_b[7:0]))  : DATA_W'(lane_b[7:0]);
            2'd1:    return sgn ? DATA_W'($signed(lane_h[15:0])) : DATA_W'(lane_h[15:0]);
            default: return d;
        endcase
    endfunction

    // Decode the write committing at the next edge.
    always_comb begin
        sel_dst    = '0;
        sel_data   = '0;
        do_write   = 1'b0;
        start_wait = 1'b0;
        if (state == WAIT_LOAD) begin
            if (load_valid) begin
                do_write = 1'b1;
                sel_dst  = pend_dst;
                sel_data = extract(load_data, pend_size, pend_sgn, pend_off);
            end
        end else if (wb_valid) begin
            case (wb_type)
                WB_RR: begin
                    do_write = 1'b1;
                    sel_dst  = wb_ir[15:11];
                    sel_data = alu_result;
                end
                WB_RM: begin
                    do_write = 1'b1;
                    sel_dst  = wb_ir[20:16];
                    sel_data = alu_result;
                end
                WB_LOAD: begin
                    sel_dst = wb_ir[20:16];
                    if (load_valid) begin
                        do_write = 1'b1;
                        sel_data = extract(load_data, ld_size, ld_signed, ld_offset);
                    end else begin
                        start_wait = 1'b1;
                    end
                end
                WB_LINK: begin
                    do_write = 1'b1;
                    sel_dst  = FIELD_W'(31);
                    sel_data = link_addr;
                end
                default: ;
            endcase
        end
    end

    assign dst_ok   = (sel_dst != '0) && (32'(sel_dst) < NREG);
    assign fwd_en   = rst_n && do_write && dst_ok;
    assign fwd_addr = fwd_en ? ADDR_W'(sel_dst) : '0;
    assign fwd_data = fwd_en ? sel_data : '0;
    assign wb_ready = !rst_n || (state == RUN);

    // State, pending-load latches and register array.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            pend_dst  <= '0;
            pend_size <= '0;
            pend_off  <= '0;
            pend_sgn  <= 1'b0;
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (fwd_en) begin
                regs[IDX_W'(fwd_addr)] <= fwd_data;
            end
            if (state == RUN) begin
                if (start_wait) begin
                    state     <= WAIT_LOAD;
                    pend_dst  <= wb_ir[20:16];
                    pend_size <= ld_size;
                    pend_off  <= ld_offset;
                    pend_sgn  <= ld_signed;
                end
            end else if (load_valid) begin
                state <= RUN;
            end
        end
    end

    // Read ports with write-through bypass of the in-flight write.
    for (genvar p = 0; p < int'(NREAD); p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;
        assign ra = rd_addr[p*ADDR_W +: ADDR_W];
        always_comb begin
            rv = '0;
            if (fwd_en && (ra == fwd_addr)) begin
                rv = fwd_data;
            end else if ((ra != '0) && (32'(ra) < NREG)) begin
                rv = regs[IDX_W'(ra)];
            end
        end
        assign rd_data[p*DATA_W +: DATA_W] = rv;
    end

endmodule
